mc6803_timer_gen3: RTL and testbench
====================================

// Module: mc6803_timer_gen3
// PURPOSE
//  Parametrised successor to the on-chip 6801/6803 programmable timer.
//  - Free-running 16-bit counter with prescaler.
//  - NUM_OC output-compare channels, each with a pin-level output.
//  - One input-capture channel with a 2-flop synchroniser.
//  - 6801-style flag-clear sequences, plus coherent 16-bit counter reads and coherent OCR writes.
//  - Sits on the CPU internal register bus beside port/DDR/iRAM decode; the parent asserts sel
//    for the timer window.
// PARAMETERS
//  NUM_OC      2        number of output-compare channels, 1..4
//  PRESCALE_W  0        counter ticks every 2**PRESCALE_W clks (0 = every clk)
//  CNT_PRESET  16'hFFF8 counter value loaded by any write to CNT_H
//  ADDR_W      4        register offset width
// PORTS
//  clk      in   1         system clock, all state on posedge
//  RST_n    in   1         asynchronous active-low reset
//  sel      in   1         register access this cycle (vma & window decode), one clk per access
//  wr       in   1         1 = write, 0 = read (only meaningful with sel)
//  addr     in   ADDR_W    register offset
//  wdata    in   8         write data
//  rdata    out  8         read data, combinational from addr; 8'h00 for unmapped offsets
//  icap_in  in   1         asynchronous input-capture pin
//  tout     out  NUM_OC    output-compare pin levels
//  irq_ocf  out  1         |(OCF & EOCI)
//  irq_tof  out  1         TOF & ETOI
//  irq_icf  out  1         ICF & EICI
// BEHAVIOUR
//  Register map:
//   - 0 STAT    RO:  [7] ICF, [6] TOF, [3:0] OCF[k]
//   - 1 CTRL    RW:  [7:4] OLVL[k], [3:0] EOCI[k]
//   - 2 CTRL2   RW:  [2] IEDG, [1] ETOI, [0] EICI
//   - 3/4 CNT_H/L
//   - 5/6 ICR_H/L   RO
//   - 7+2k / 8+2k   OCR_H[k] / OCR_L[k]
//   - Bits and registers for k >= NUM_OC read 0 and ignore writes.
//  Reset (RST_n low, async):
//   - counter = 0, prescaler = 0; all OCR and ICR = 16'hFFFF.
//   - All flags, enables, OLVL, IEDG, arm bits, latches = 0.
//   - tout = 0, irq_* = 0, rdata follows the reset registers.
//  Prescaler / counter:
//   - tick = prescaler at all-ones; the counter increments by 1 on tick and wraps FFFF -> 0000.
//   - TOF is set on the tick that takes the counter from FFFF to 0000.
//   - Write CNT_H (any data): counter = CNT_PRESET and prescaler = 0 next clk; that cycle's tick
//     is discarded.
//   - Writes to CNT_L are ignored.
//  Coherent read:
//   - Reading CNT_H returns counter[15:8] and latches counter[7:0] into cnt_lo_buf.
//   - Reading CNT_L returns cnt_lo_buf if a CNT_H read occurred since the last CNT_L read,
//     else the live counter[7:0].
//  Coherent OCR write:
//   - Writing OCR_H[k] loads hold_h[k] only.
//   - Writing OCR_L[k] commits OCR[k] = {hold_h[k], wdata} in one clk.
//   - OCR reads return committed values.
//  Output compare:
//   - Evaluated only on tick: if the post-increment counter == OCR[k], then next clk
//     OCF[k] = 1 and tout[k] = OLVL[k].
//   - A compare is not generated by an OCR commit alone.
//  Input capture:
//   - icap_in passes through a 2-flop sync, then edge detect (IEDG = 1 rising, 0 falling).
//   - On a detected edge: ICR = current counter and ICF = 1.
//   - Latency from pin change to ICF visible is 3 clks.
//  Flag clear (two-step, per flag):
//   - A STAT read while the flag = 1 sets that flag's arm bit.
//   - TOF clears on a subsequent CNT_H read; ICF on a subsequent ICR_H read; OCF[k] on a
//     subsequent write to OCR_H[k] or OCR_L[k].
//   - The clearing access also clears the arm bit.
//   - An unarmed access leaves the flag unchanged.
//   - Set and clear in the same clk: set wins and the arm bit is cleared.
//  Interrupts:
//   - irq_* are combinational from registered flags and enables; there is no internal masking
//     beyond the E bits.
//  Reset mid-operation:
//   - Reset drops all state immediately; an in-flight hold_h is discarded, so no partial OCR
//     commit survives.
// TESTING
//  1. Reset, PRESCALE_W = 0, wait 65536 clks -> counter wraps to 0000, TOF = 1, irq_tof = 0;
//     then write CTRL2 = 8'h02 -> irq_tof = 1.
//  2. Read STAT (TOF = 1), then read CNT_H -> TOF = 0 next clk. Without the STAT read, a CNT_H
//     read leaves TOF = 1.
//  3. Write OCR_H[1] = 8'h01, OCR_L[1] = 8'h00, CTRL = 8'h22 -> at the count 16'h0100 tick,
//     OCF[1] = 1, tout[1] = 1, irq_ocf = 1.
//  4. Write CNT_H = 8'h55 -> counter = FFF8. Read CNT_H then CNT_L 3 clks later -> the pair
//     equals the value at the CNT_H read.
//  5. IEDG = 1, rising icap_in at counter 16'h1234 -> ICF = 1 after 3 clks, ICR = 16'h1236.
//     A falling edge causes no capture.
//  6. PRESCALE_W = 2: counter advances once per 4 clks. A STAT arm plus counter-wrap set in the
//     same clk as the CNT_H read leaves TOF = 1.

Source files
------------

// File: rtl/mc6803_timer_gen3.sv
// 6801/6803-style programmable timer: prescaled free-running counter, NUM_OC output
// compares, one synchronised input capture, coherent 16-bit access and two-step flag clearing.
module mc6803_timer_gen3 #(
  parameter int          NUM_OC     = 2,
  parameter int          PRESCALE_W = 0,
  parameter logic [15:0] CNT_PRESET = 16'hFFF8,
  parameter int          ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              RST_n,
  input  logic              sel,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  input  logic              icap_in,
  output logic [NUM_OC-1:0] tout,
  output logic              irq_ocf,
  output logic              irq_tof,
  output logic              irq_icf
);
  localparam int PW = (PRESCALE_W > 0) ? PRESCALE_W : 1;

  logic [15:0]       cnt_q, cnt_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tof_q, tof_d, tofArm_q, tofArm_d;
  logic              icf_q, icf_d, icfArm_q, icfArm_d;
  logic [NUM_OC-1:0] ocf_q, ocf_d, ocfArm_q, ocfArm_d;
  logic [NUM_OC-1:0] olvl_q, olvl_d, eoci_q, eoci_d, tout_q, tout_d;
  logic              iedg_q, iedg_d, etoi_q, etoi_d, eici_q, eici_d;
  logic [15:0]       icr_q, icr_d;
  logic [15:0]       ocr_q [NUM_OC];
  logic [15:0]       ocr_d [NUM_OC];
  logic [7:0]        holdH_q [NUM_OC];
  logic [7:0]        holdH_d [NUM_OC];
  logic [7:0]        cntLoBuf_q, cntLoBuf_d;
  logic              loPend_q, loPend_d;
  logic              sync1_q, sync2_q, sync3_q;

  logic              rdAcc, wrAcc, statRd, ctrlWr, ctrl2Wr, cntHRd, cntLRd, cntHWr, icrHRd;
  logic [NUM_OC-1:0] ocrHWr, ocrLWr;
  logic              tick, effTick, capEdge;
  logic [15:0]       cntInc;
  logic [3:0]        ocfPad, olvlPad, eociPad;

  assign rdAcc   = sel & ~wr;
  assign wrAcc   = sel & wr;
  assign statRd  = rdAcc && (addr == ADDR_W'(0));
  assign ctrlWr  = wrAcc && (addr == ADDR_W'(1));
  assign ctrl2Wr = wrAcc && (addr == ADDR_W'(2));
  assign cntHRd  = rdAcc && (addr == ADDR_W'(3));
  assign cntHWr  = wrAcc && (addr == ADDR_W'(3));
  assign cntLRd  = rdAcc && (addr == ADDR_W'(4));
  assign icrHRd  = rdAcc && (addr == ADDR_W'(5));

  // A counter-high write restarts the prescaler, so the tick of that cycle never happens.
  assign tick    = (PRESCALE_W == 0) ? 1'b1 : &presc_q;
  assign effTick = tick & ~cntHWr;
  assign cntInc  = cnt_q + 16'd1;
  assign capEdge = iedg_q ? (sync2_q & ~sync3_q) : (sync3_q & ~sync2_q);

  always_comb begin
    ocrHWr = '0;
    ocrLWr = '0;
    for (int k = 0; k < NUM_OC; k++) begin
      ocrHWr[k] = wrAcc && (addr == ADDR_W'(7 + 2 * k));
      ocrLWr[k] = wrAcc && (addr == ADDR_W'(8 + 2 * k));
    end
  end

  always_comb begin
    presc_d    = (PRESCALE_W == 0) ? '0 : presc_q + PW'(1);
    cnt_d      = cnt_q;
    olvl_d     = olvl_q;
    eoci_d     = eoci_q;
    iedg_d     = iedg_q;
    etoi_d     = etoi_q;
    eici_d     = eici_q;
    icr_d      = icr_q;
    cntLoBuf_d = cntLoBuf_q;
    loPend_d   = loPend_q;
    ocf_d      = ocf_q;
    ocfArm_d   = ocfArm_q;
    tout_d     = tout_q;
    for (int k = 0; k < NUM_OC; k++) begin
      ocr_d[k]   = ocr_q[k];
      holdH_d[k] = holdH_q[k];
    end

    if (cntHWr) begin
      cnt_d   = CNT_PRESET;
      presc_d = '0;
    end else if (tick) begin
      cnt_d = cntInc;
    end

    if (ctrlWr) begin
      olvl_d = wdata[4 +: NUM_OC];
      eoci_d = wdata[NUM_OC-1:0];
    end
    if (ctrl2Wr) begin
      iedg_d = wdata[2];
      etoi_d = wdata[1];
      eici_d = wdata[0];
    end

    if (cntHRd) begin
      cntLoBuf_d = cnt_q[7:0];
      loPend_d   = 1'b1;
    end else if (cntLRd) begin
      loPend_d = 1'b0;
    end

    // Flag priority: a new set beats a clear, but the clearing access always consumes the arm.
    tof_d    = (effTick && cnt_q == 16'hFFFF) | (tof_q & ~(cntHRd & tofArm_q));
    tofArm_d = (cntHRd & tofArm_q) ? 1'b0 : (tofArm_q | (statRd & tof_q));

    if (capEdge) icr_d = cnt_q;
    icf_d    = capEdge | (icf_q & ~(icrHRd & icfArm_q));
    icfArm_d = (icrHRd & icfArm_q) ? 1'b0 : (icfArm_q | (statRd & icf_q));

    for (int k = 0; k < NUM_OC; k++) begin
      if (ocrHWr[k]) holdH_d[k] = wdata;
      if (ocrLWr[k]) ocr_d[k] = {holdH_q[k], wdata};
      if ((ocrHWr[k] | ocrLWr[k]) & ocfArm_q[k]) begin
        ocf_d[k]    = 1'b0;
        ocfArm_d[k] = 1'b0;
      end else if (statRd & ocf_q[k]) begin
        ocfArm_d[k] = 1'b1;
      end
      if (effTick && cntInc == ocr_q[k]) begin
        ocf_d[k]  = 1'b1;
        tout_d[k] = olvl_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q      <= '0;
      presc_q    <= '0;
      tof_q      <= 1'b0;
      tofArm_q   <= 1'b0;
      icf_q      <= 1'b0;
      icfArm_q   <= 1'b0;
      ocf_q      <= '0;
      ocfArm_q   <= '0;
      olvl_q     <= '0;
      eoci_q     <= '0;
      tout_q     <= '0;
      iedg_q     <= 1'b0;
      etoi_q     <= 1'b0;
      eici_q     <= 1'b0;
      icr_q      <= 16'hFFFF;
      cntLoBuf_q <= '0;
      loPend_q   <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      for (int k = 0; k < NUM_OC; k++) begin
        ocr_q[k]   <= 16'hFFFF;
        holdH_q[k] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      tof_q      <= tof_d;
      tofArm_q   <= tofArm_d;
      icf_q      <= icf_d;
      icfArm_q   <= icfArm_d;
      ocf_q      <= ocf_d;
      ocfArm_q   <= ocfArm_d;
      olvl_q     <= olvl_d;
      eoci_q     <= eoci_d;
      tout_q     <= tout_d;
      iedg_q     <= iedg_d;
      etoi_q     <= etoi_d;
      eici_q     <= eici_d;
      icr_q      <= icr_d;
      cntLoBuf_q <= cntLoBuf_d;
      loPend_q   <= loPend_d;
      sync1_q    <= icap_in;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      for (int k = 0; k < NUM_OC; k++) begin
        ocr_q[k]   <= ocr_d[k];
        holdH_q[k] <= holdH_d[k];
      end
    end
  end

  assign tout    = tout_q;
  assign irq_ocf = |(ocf_q & eoci_q);
  assign irq_tof = tof_q & etoi_q;
  assign irq_icf = icf_q & eici_q;

  always_comb begin
    rdata   = 8'h00;
    ocfPad  = '0;
    olvlPad = '0;
    eociPad = '0;
    ocfPad[NUM_OC-1:0]  = ocf_q;
    olvlPad[NUM_OC-1:0] = olvl_q;
    eociPad[NUM_OC-1:0] = eoci_q;
    case (addr)
      ADDR_W'(0): rdata = {icf_q, tof_q, 2'b00, ocfPad};
      ADDR_W'(1): rdata = {olvlPad, eociPad};
      ADDR_W'(2): rdata = {5'b00000, iedg_q, etoi_q, eici_q};
      ADDR_W'(3): rdata = cnt_q[15:8];
      ADDR_W'(4): rdata = loPend_q ? cntLoBuf_q : cnt_q[7:0];
      ADDR_W'(5): rdata = icr_q[15:8];
      ADDR_W'(6): rdata = icr_q[7:0];
      default:    rdata = 8'h00;
    endcase
    for (int k = 0; k < NUM_OC; k++) begin
      if (addr == ADDR_W'(7 + 2 * k)) rdata = ocr_q[k][15:8];
      if (addr == ADDR_W'(8 + 2 * k)) rdata = ocr_q[k][7:0];
    end
  end

endmodule

// File: tb/tb_mc6803_timer_gen3.sv
// Directed bench for mc6803_timer_gen3: one instance with no prescale, one with PRESCALE_W = 2.
module tb_mc6803_timer_gen3;
  localparam logic [3:0] STAT = 4'd0, CTRL = 4'd1, CTRL2 = 4'd2, CNTH = 4'd3, CNTL = 4'd4;
  localparam logic [3:0] ICRH = 4'd5, ICRL = 4'd6;

  logic       clk = 1'b0;
  logic       RST_n = 1'b1;
  logic       sel1 = 1'b0, sel2 = 1'b0, wr = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] wdata = 8'h00;
  logic       icap_in = 1'b0;
  logic [7:0] rdata1, rdata2;
  logic [1:0] tout1, tout2;
  logic       irqOcf1, irqTof1, irqIcf1, irqOcf2, irqTof2, irqIcf2;
  logic [7:0] rd;
  int         testsRun = 0;
  int         testsFailed = 0;

  always #5 clk = ~clk;

  mc6803_timer_gen3 #(.NUM_OC(2), .PRESCALE_W(0), .CNT_PRESET(16'hFFF8), .ADDR_W(4)) dut (
    .clk(clk), .RST_n(RST_n), .sel(sel1), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .icap_in(icap_in), .tout(tout1),
    .irq_ocf(irqOcf1), .irq_tof(irqTof1), .irq_icf(irqIcf1));

  mc6803_timer_gen3 #(.NUM_OC(2), .PRESCALE_W(2), .CNT_PRESET(16'hFFF8), .ADDR_W(4)) dut2 (
    .clk(clk), .RST_n(RST_n), .sel(sel2), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .icap_in(1'b0), .tout(tout2),
    .irq_ocf(irqOcf2), .irq_tof(irqTof2), .irq_icf(irqIcf2));

  // Bus access tasks start at a negedge, hold sel across one posedge and return at the next negedge.
  task automatic busWrite(input bit which, input logic [3:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1;
    if (which) sel2 = 1'b1; else sel1 = 1'b1;
    @(negedge clk);
    sel1 = 1'b0; sel2 = 1'b0; wr = 1'b0;
  endtask

  task automatic busRead(input bit which, input logic [3:0] a, output logic [7:0] d);
    addr = a; wr = 1'b0;
    if (which) sel2 = 1'b1; else sel1 = 1'b1;
    #1 d = which ? rdata2 : rdata1;
    @(negedge clk);
    sel1 = 1'b0; sel2 = 1'b0;
  endtask

  task automatic test_reset;
    #2 RST_n = 1'b0;
    @(negedge clk);
    busRead(0, STAT, rd);
    testsRun++; if (rd !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_stat got %h want 00", rd); end
    busRead(0, CNTL, rd);
    testsRun++; if (rd !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_cntl got %h want 00", rd); end
    busRead(0, ICRH, rd);
    testsRun++; if (rd !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_icrh got %h want ff", rd); end
    busRead(0, 4'd10, rd);
    testsRun++; if (rd !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_ocrl1 got %h want ff", rd); end
    testsRun++;
    if ({tout1, irqOcf1, irqTof1, irqIcf1} !== 5'b0) begin
      testsFailed++; $display("[TB] FAIL reset_outs got %b want 00000", {tout1, irqOcf1, irqTof1, irqIcf1});
    end
    RST_n = 1'b1;
  endtask

  task automatic test_overflow;
    repeat (65535) @(negedge clk);
    busRead(0, STAT, rd);
    testsRun++; if (rd !== 8'h03) begin testsFailed++; $display("[TB] FAIL pre_wrap_stat got %h want 03", rd); end
    testsRun++; if (irqTof1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL tof_masked got %b want 0", irqTof1); end
    busRead(0, STAT, rd);
    testsRun++; if (rd !== 8'h43) begin testsFailed++; $display("[TB] FAIL wrap_stat got %h want 43", rd); end
    busWrite(0, CTRL2, 8'h02);
    testsRun++; if (irqTof1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL irq_tof_en got %b want 1", irqTof1); end
  endtask

  task automatic test_tof_clear;
    busRead(0, CNTH, rd);
    testsRun++; if (rd !== 8'h00) begin testsFailed++; $display("[TB] FAIL armed_cnth got %h want 00", rd); end
    busRead(0, STAT, rd);
    testsRun++; if (rd !== 8'h03) begin testsFailed++; $display("[TB] FAIL tof_cleared got %h want 03", rd); end
    testsRun++; if (irqTof1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_tof_clr got %b want 0", irqTof1); end
    busWrite(0, CNTH, 8'h55);
    repeat (8) @(negedge clk);
    testsRun++; if (irqTof1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL preset_wrap got %b want 1", irqTof1); end
    busRead(0, CNTH, rd);
    busRead(0, STAT, rd);
    testsRun++; if (rd !== 8'h43) begin testsFailed++; $display("[TB] FAIL unarmed_keep got %h want 43", rd); end
    busRead(0, CNTH, rd);
    busRead(0, STAT, rd);
    testsRun++; if (rd !== 8'h03) begin testsFailed++; $display("[TB] FAIL armed_clear got %h want 03", rd); end
  endtask

  task automatic test_output_compare;
    busWrite(0, 4'd9, 8'h01);
    busRead(0, 4'd9, rd);
    testsRun++; if (rd !== 8'hFF) begin testsFailed++; $display("[TB] FAIL ocr_uncommitted got %h want ff", rd); end
    busWrite(0, 4'd10, 8'h00);
    busRead(0, 4'd9, rd);
    testsRun++; if (rd !== 8'h01) begin testsFailed++; $display("[TB] FAIL ocr1_h got %h want 01", rd); end
    busRead(0, 4'd10, rd);
    testsRun++; if (rd !== 8'h00) begin testsFailed++; $display("[TB] FAIL ocr1_l got %h want 00", rd); end
    busWrite(0, 4'd7, 8'hFF);
    busWrite(0, 4'd8, 8'hFF);
    busWrite(0, CTRL, 8'h22);
    busRead(0, STAT, rd);
    testsRun++; if (rd !== 8'h00) begin testsFailed++; $display("[TB] FAIL ocf_cleared got %h want 00", rd); end
    busWrite(0, CNTH, 8'h55);
    repeat (263) @(negedge clk);
    testsRun++;
    if ({tout1, irqOcf1} !== 3'b000) begin testsFailed++; $display("[TB] FAIL pre_match got %b want 000", {tout1, irqOcf1}); end
    @(negedge clk);
    testsRun++;
    if ({tout1, irqOcf1} !== 3'b101) begin testsFailed++; $display("[TB] FAIL match_0100 got %b want 101", {tout1, irqOcf1}); end
    busRead(0, STAT, rd);
    testsRun++; if (rd !== 8'h43) begin testsFailed++; $display("[TB] FAIL match_stat got %h want 43", rd); end
  endtask

  task automatic test_coherent_read;
    busWrite(0, CNTH, 8'h55);
    busRead(0, CNTH, rd);
    testsRun++; if (rd !== 8'hFF) begin testsFailed++; $display("[TB] FAIL coh_hi got %h want ff", rd); end
    repeat (2) @(negedge clk);
    busRead(0, CNTL, rd);
    testsRun++; if (rd !== 8'hF8) begin testsFailed++; $display("[TB] FAIL coh_lo got %h want f8", rd); end
    busRead(0, CNTL, rd);
    testsRun++; if (rd !== 8'hFC) begin testsFailed++; $display("[TB] FAIL live_lo got %h want fc", rd); end
  endtask

  task automatic test_input_capture;
    busWrite(0, CTRL2, 8'h05);
    busWrite(0, CNTH, 8'h55);
    repeat (4668) @(negedge clk);
    icap_in = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++; if (irqIcf1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL icf_early got %b want 0", irqIcf1); end
    @(negedge clk);
    testsRun++; if (irqIcf1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL icf_3clk got %b want 1", irqIcf1); end
    busRead(0, ICRH, rd);
    testsRun++; if (rd !== 8'h12) begin testsFailed++; $display("[TB] FAIL icr_h got %h want 12", rd); end
    busRead(0, ICRL, rd);
    testsRun++; if (rd !== 8'h36) begin testsFailed++; $display("[TB] FAIL icr_l got %h want 36", rd); end
    busRead(0, STAT, rd);
    testsRun++; if (rd !== 8'hC3) begin testsFailed++; $display("[TB] FAIL cap_stat got %h want c3", rd); end
    busRead(0, ICRH, rd);
    testsRun++; if (irqIcf1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL icf_clear got %b want 0", irqIcf1); end
    icap_in = 1'b0;
    repeat (4) @(negedge clk);
    testsRun++; if (irqIcf1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL fall_nocap got %b want 0", irqIcf1); end
    busRead(0, ICRL, rd);
    testsRun++; if (rd !== 8'h36) begin testsFailed++; $display("[TB] FAIL icr_kept got %h want 36", rd); end
  endtask

  task automatic test_regmap;
    busWrite(0, 4'd11, 8'hAA);
    busRead(0, 4'd11, rd);
    testsRun++; if (rd !== 8'h00) begin testsFailed++; $display("[TB] FAIL unmapped_11 got %h want 00", rd); end
    busWrite(0, CTRL, 8'hFF);
    busRead(0, CTRL, rd);
    testsRun++; if (rd !== 8'h33) begin testsFailed++; $display("[TB] FAIL ctrl_mask got %h want 33", rd); end
    busWrite(0, CTRL2, 8'hFF);
    busRead(0, CTRL2, rd);
    testsRun++; if (rd !== 8'h07) begin testsFailed++; $display("[TB] FAIL ctrl2_mask got %h want 07", rd); end
  endtask

  task automatic test_back_to_back;
    busWrite(1, CNTH, 8'h00);
    repeat (3) @(negedge clk);
    busRead(1, CNTL, rd);
    testsRun++; if (rd !== 8'hF8) begin testsFailed++; $display("[TB] FAIL presc_hold got %h want f8", rd); end
    busRead(1, CNTL, rd);
    testsRun++; if (rd !== 8'hF9) begin testsFailed++; $display("[TB] FAIL presc_tick got %h want f9", rd); end
    repeat (27) @(negedge clk);
    busRead(1, STAT, rd);
    testsRun++; if (rd !== 8'h43) begin testsFailed++; $display("[TB] FAIL p2_wrap got %h want 43", rd); end
    busWrite(1, CNTH, 8'h00);
    repeat (31) @(negedge clk);
    busRead(1, CNTH, rd);
    testsRun++; if (rd !== 8'hFF) begin testsFailed++; $display("[TB] FAIL p2_cnth got %h want ff", rd); end
    busRead(1, CNTH, rd);
    testsRun++; if (rd !== 8'h00) begin testsFailed++; $display("[TB] FAIL p2_after got %h want 00", rd); end
    busRead(1, STAT, rd);
    testsRun++; if (rd !== 8'h43) begin testsFailed++; $display("[TB] FAIL set_wins got %h want 43", rd); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_tof_clear();
    test_output_compare();
    test_coherent_read();
    test_input_capture();
    test_regmap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
